mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: DATA_W, default 32, data bus width.
REQ-002 Parameter: ADDR_W, default 32, byte address width.
REQ-003 Parameter: MAX_DM_STREAK, default 4, consecutive data grants allowed while a fetch waits; legal range 1..15.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high.
REQ-006 if_req  input  1  fetch request; held until if_ack.
REQ-007 if_addr  input  ADDR_W  fetch address.
REQ-008 if_rdata  output  DATA_W  fetched instruction; valid while if_ack=1.
REQ-009 if_ack  output  1  one-cycle completion pulse to fetch.
REQ-010 dm_req  input  1  data request; held until dm_ack.
REQ-011 dm_we  input  1  1 = store, 0 = load.
REQ-012 dm_addr  input  ADDR_W  data address.
REQ-013 dm_wdata  input  DATA_W  store data.
REQ-014 dm_rdata  output  DATA_W  load data; valid while dm_ack=1.
REQ-015 dm_ack  output  1  one-cycle completion pulse to data port.
REQ-016 mem_req  output  1  request to the shared single-port memory.
REQ-017 mem_we  output  1  write strobe to memory.
REQ-018 mem_addr  output  ADDR_W  memory address.
REQ-019 mem_wdata  output  DATA_W  memory write data.
REQ-020 mem_rdata  input  DATA_W  memory read data; valid with mem_ready.
REQ-021 mem_ready  input  1  memory completion, variable latency of 1 or more cycles.
REQ-022 if_stall, dm_stall  output  1 each  = port req AND NOT port ack (combinational); drives pipeline PC/IFID write enables.

Function
REQ-023 FSM states: IDLE, IF_BUSY, DM_BUSY, IF_RESP, DM_RESP.
REQ-024 In IDLE, grant DM when dm_req=1 and (if_req=0 or streak<MAX_DM_STREAK); otherwise grant IF when if_req=1; otherwise stay in IDLE.
REQ-025 On a grant, latch the owner's addr/we/wdata; IF grant forces mem_we=0; the next state is the matching BUSY state.
REQ-026 In a BUSY state: mem_req=1 and mem_addr/mem_we/mem_wdata come from the latched values; port input changes are ignored.
REQ-027 On BUSY with mem_ready=1: capture mem_rdata into the owner's rdata register and go to the matching RESP state.
REQ-028 In a RESP state: the owner's ack=1 for exactly one cycle, then IDLE; no new grant is issued in the RESP cycle.
REQ-029 Latency: request sampled in IDLE at cycle t, mem_ready at t+k (k≥1) gives ack at t+k+1; minimum is 2 cycles after the grant edge.
REQ-030 Streak counter, 4 bits: increments (saturating at MAX_DM_STREAK) on a DM grant with if_req=1; clears on an IF grant and on a DM grant with if_req=0.
REQ-031 Stores return dm_ack with dm_rdata = captured mem_rdata (don't-care to the requester).
REQ-032 mem_ready outside BUSY states is ignored.
REQ-033 If the owner drops req during BUSY, the transaction still completes and ack is still pulsed.
REQ-034 mem_req=0 and both acks=0 in IDLE; mem_we=0 whenever mem_req=0.

Reset
REQ-035 reset=1 at an edge forces: state=IDLE, streak=0, latched addr/wdata/rdata=0, mem_req=0, mem_we=0, if_ack=0, dm_ack=0.
REQ-036 Reset mid-transaction abandons it: no ack is issued, mem_req is low from the next cycle, and the requester must re-issue.
REQ-037 A request present in the first cycle after reset release is arbitrated normally.

Structure
REQ-038 Shared package mips_mem_pkg holds: the state enum, owner codes (NONE=0, IF=1, DM=2), and DATA_W/ADDR_W defaults.
REQ-039 Single module with no sub-modules; the streak counter is inline.

Verification
REQ-040 Single fetch: if_req=1, if_addr=0x00000010, memory returns 0x8C010004 with 2-cycle latency -> if_ack one pulse 3 cycles after grant, if_rdata=0x8C010004, mem_we=0 throughout.
REQ-041 Collision: if_req and dm_req (store, addr 0x100, wdata 0xDEADBEEF) asserted in the same cycle -> DM granted first, mem_we=1 with addr 0x100; IF granted after dm_ack; if_stall=1 until if_ack.
REQ-042 Starvation: if_req held high, dm_req re-asserted right after every ack, MAX_DM_STREAK=4 -> exactly 4 DM grants, then 1 IF grant, streak back to 0.
REQ-043 Reset mid-op: reset asserted while DM_BUSY, before mem_ready -> mem_req=0 next cycle, no dm_ack, state IDLE, streak=0.
REQ-044 Stray/held inputs: mem_ready=1 in IDLE -> no ack; if_addr changed from 0x20 to 0x40 during IF_BUSY -> mem_addr stays 0x20.

Source files
------------

// File: rtl/mips_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_mem_pkg
// Description : Shared arbiter state encoding, owner codes and bus defaults.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_mem_pkg;

    localparam int c_DEF_DATA_W = 32;
    localparam int c_DEF_ADDR_W = 32;
    localparam int c_STREAK_W   = 4;

    typedef enum logic [2:0] {
        ARB_IDLE    = 3'd0,
        ARB_IF_BUSY = 3'd1,
        ARB_DM_BUSY = 3'd2,
        ARB_IF_RESP = 3'd3,
        ARB_DM_RESP = 3'd4
    } arb_state_e;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_IF   = 2'd1,
        OWNER_DM   = 2'd2
    } owner_e;

    // Which port a given arbiter state is serving.
    function automatic owner_e owner_of(input logic [2:0] st);
        case (st)
            ARB_IF_BUSY, ARB_IF_RESP: return OWNER_IF;
            ARB_DM_BUSY, ARB_DM_RESP: return OWNER_DM;
            default:                  return OWNER_NONE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Fetch/data arbiter in front of one single-port memory, with
//               bounded data-port priority so fetch cannot starve.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int DATA_W        = c_DEF_DATA_W,
    parameter int ADDR_W        = c_DEF_ADDR_W,
    parameter int MAX_DM_STREAK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    output logic              dm_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam logic [2:0] c_ST_IDLE    = ARB_IDLE;
    localparam logic [2:0] c_ST_IF_BUSY = ARB_IF_BUSY;
    localparam logic [2:0] c_ST_DM_BUSY = ARB_DM_BUSY;
    localparam logic [2:0] c_ST_IF_RESP = ARB_IF_RESP;
    localparam logic [2:0] c_ST_DM_RESP = ARB_DM_RESP;

    // Out-of-range streak limits are pulled into 1..15 so the 4-bit counter stays meaningful.
    localparam int c_MAX_CLAMP = (MAX_DM_STREAK < 1)  ? 1  :
                                 (MAX_DM_STREAK > 15) ? 15 : MAX_DM_STREAK;
    localparam logic [c_STREAK_W-1:0] c_MAX_STREAK = c_STREAK_W'(c_MAX_CLAMP);

    logic [2:0]            r_state;
    logic [2:0]            w_state_nxt;
    logic [c_STREAK_W-1:0] r_streak;
    logic [ADDR_W-1:0]     r_addr;
    logic                  r_we;
    logic [DATA_W-1:0]     r_wdata;
    logic [DATA_W-1:0]     r_if_rdata;
    logic [DATA_W-1:0]     r_dm_rdata;
    logic                  w_idle;
    logic                  w_busy;
    logic                  w_grant_dm;
    logic                  w_grant_if;
    owner_e                w_owner;

    assign w_idle  = (r_state == c_ST_IDLE);
    assign w_busy  = (r_state == c_ST_IF_BUSY) || (r_state == c_ST_DM_BUSY);
    assign w_owner = owner_of(r_state);

    // Data wins unless fetch is waiting and data has already used up its streak.
    assign w_grant_dm = w_idle && dm_req && (!if_req || (r_streak < c_MAX_STREAK));
    assign w_grant_if = w_idle && !w_grant_dm && if_req;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_grant_dm) begin
                    w_state_nxt = c_ST_DM_BUSY;
                end else if (w_grant_if) begin
                    w_state_nxt = c_ST_IF_BUSY;
                end
            end
            c_ST_IF_BUSY: begin
                if (mem_ready) begin
                    w_state_nxt = c_ST_IF_RESP;
                end
            end
            c_ST_DM_BUSY: begin
                if (mem_ready) begin
                    w_state_nxt = c_ST_DM_RESP;
                end
            end
            c_ST_IF_RESP: w_state_nxt = c_ST_IDLE;
            c_ST_DM_RESP: w_state_nxt = c_ST_IDLE;
            default:      w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_ST_IDLE;
            r_streak   <= '0;
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_wdata    <= '0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (w_grant_dm) begin
                r_addr  <= dm_addr;
                r_we    <= dm_we;
                r_wdata <= dm_wdata;
                if (!if_req) begin
                    r_streak <= '0;
                end else if (r_streak < c_MAX_STREAK) begin
                    r_streak <= r_streak + 4'd1;
                end
            end else if (w_grant_if) begin
                r_addr   <= if_addr;
                r_we     <= 1'b0;
                r_wdata  <= '0;
                r_streak <= '0;
            end

            if (w_busy && mem_ready) begin
                if (w_owner == OWNER_IF) begin
                    r_if_rdata <= mem_rdata;
                end else begin
                    r_dm_rdata <= mem_rdata;
                end
            end
        end
    end

    assign mem_req   = w_busy;
    assign mem_we    = w_busy && r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

    assign if_ack   = (r_state == c_ST_IF_RESP);
    assign dm_ack   = (r_state == c_ST_DM_RESP);
    assign if_rdata = r_if_rdata;
    assign dm_rdata = r_dm_rdata;

    // Stalls are combinational so the pipeline releases in the ack cycle itself.
    assign if_stall = if_req && !if_ack;
    assign dm_stall = dm_req && !dm_ack;

endmodule
`default_nettype wire
